// File: rtl/mem_access_if.sv
// Request/response and RAM-port bundle for the mem_access load/store sequencer,
// plus the RAM command encodings shared by the sequencer and the RAM.
`ifndef RAM_NOP
`define RAM_NOP   2'd0
`endif
`ifndef RAM_READ
`define RAM_READ  2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

interface mem_access_if;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_fault;
    logic [31:0] o_rdata;
    logic [1:0]  o_ram_do;
    logic [31:0] o_ram_addr;
    logic [31:0] o_ram_val;
    logic [31:0] i_ram_val;

    modport slave (
        input  i_req, i_we, i_size, i_signed, i_addr, i_wdata, i_ram_val,
        output o_ready, o_done, o_fault, o_rdata, o_ram_do, o_ram_addr, o_ram_val
    );

    modport master (
        output i_req, i_we, i_size, i_signed, i_addr, i_wdata, i_ram_val,
        input  o_ready, o_done, o_fault, o_rdata, o_ram_do, o_ram_addr, o_ram_val
    );
endinterface

// File: rtl/mem_access.sv
// Load/store sequencer in front of a byte-addressed big-endian 32-bit RAM; sub-word stores use RMW.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned half/word accesses at acceptance.
module mem_access #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_signed;
    logic        r_fault;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_rdword;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_misalign;
    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept = bus.i_req && (r_state == IDLE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign w_misalign = ((bus.i_size == 2'd1) && bus.i_addr[0]) ||
                        ((bus.i_size == 2'd2) && (bus.i_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Rejected requests never reach the RAM, so the range check also keeps the RAM index from wrapping.
    assign w_fault = (bus.i_size == 2'd3) || (bus.i_addr > LAST_ADDR) || w_misalign;

    always_comb begin
        w_load = bus.i_ram_val;
        case (r_size)
            2'd0: w_load = r_signed ? {{24{bus.i_ram_val[31]}}, bus.i_ram_val[31:24]}
                                    : {24'd0, bus.i_ram_val[31:24]};
            2'd1: w_load = r_signed ? {{16{bus.i_ram_val[31]}}, bus.i_ram_val[31:16]}
                                    : {16'd0, bus.i_ram_val[31:16]};
            default: w_load = bus.i_ram_val;
        endcase
    end

    // The addressed byte/half sits at the top of the big-endian word; the rest is written back as read.
    always_comb begin
        w_merge = r_wdata;
        case (r_size)
            2'd0:    w_merge = {r_wdata[7:0], r_rdword[23:0]};
            2'd1:    w_merge = {r_wdata[15:0], r_rdword[15:0]};
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = DONE;
                    end else if (bus.i_we && (bus.i_size == 2'd2)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_we ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready    = 1'b0;
        bus.o_done     = 1'b0;
        bus.o_fault    = 1'b0;
        bus.o_rdata    = 32'd0;
        bus.o_ram_do   = `RAM_NOP;
        bus.o_ram_addr = 32'd0;
        bus.o_ram_val  = 32'd0;
        case (r_state)
            IDLE: bus.o_ready = 1'b1;
            RD: begin
                bus.o_ram_do   = `RAM_READ;
                bus.o_ram_addr = r_addr;
            end
            WR: begin
                bus.o_ram_do   = `RAM_WRITE;
                bus.o_ram_addr = r_addr;
                bus.o_ram_val  = w_merge;
            end
            DONE: begin
                bus.o_done  = 1'b1;
                bus.o_fault = r_fault;
                bus.o_rdata = r_rdata;
            end
            default: bus.o_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_fault  <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdword <= 24'd0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.i_we;
                r_signed <= bus.i_signed;
                r_fault  <= w_fault;
                r_size   <= bus.i_size;
                r_addr   <= bus.i_addr;
                r_wdata  <= bus.i_wdata;
                r_rdata  <= 32'd0;
            end
            if (r_state == RD) begin
                r_rdword <= bus.i_ram_val[23:0];
                if (!r_we) begin
                    r_rdata <= w_load;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: behavioural big-endian RAM, expected completions queued when driven
// and compared when the sequencer reports o_done.
`ifndef RAM_NOP
`define RAM_NOP   2'd0
`endif
`ifndef RAM_READ
`define RAM_READ  2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

module tb_mem_access;
    localparam int unsigned MEM_BYTES = 65536;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic [3:0]  lat;
        logic [3:0]  nrd;
        logic [3:0]  nwr;
        logic        addrOk;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    int   vecCount = 0;
    int   missCount = 0;

    result_t sbQ[$];
    result_t obsQ[$];

    mem_access_if bus();

    mem_access #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [15:0] ramIdx;

    assign ramIdx = bus.o_ram_addr[15:0];
    assign bus.i_ram_val = {ram[ramIdx], ram[ramIdx + 16'd1], ram[ramIdx + 16'd2], ram[ramIdx + 16'd3]};

    always @(posedge clk) begin
        if (bus.o_ram_do == `RAM_WRITE) begin
            ram[ramIdx]         <= bus.o_ram_val[31:24];
            ram[ramIdx + 16'd1] <= bus.o_ram_val[23:16];
            ram[ramIdx + 16'd2] <= bus.o_ram_val[15:8];
            ram[ramIdx + 16'd3] <= bus.o_ram_val[7:0];
        end
    end

    function automatic result_t mk(input logic f, input logic [31:0] d, input int lat,
                                   input int nrd, input int nwr);
        result_t r;
        r.fault  = f;
        r.rdata  = d;
        r.lat    = 4'(lat);
        r.nrd    = 4'(nrd);
        r.nwr    = 4'(nwr);
        r.addrOk = 1'b1;
        return r;
    endfunction

    function automatic string fmt(input result_t r);
        return $sformatf("fault=%0b rdata=%08h lat=%0d rd=%0d wr=%0d addrOk=%0b",
                         r.fault, r.rdata, r.lat, r.nrd, r.nwr, r.addrOk);
    endfunction

    // Issues one request from IDLE and records what the DUT did up to its o_done pulse.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input result_t exp);
        result_t r;
        bit seen;
        sbQ.push_back(exp);
        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = we;
        bus.i_size   = size;
        bus.i_signed = sgn;
        bus.i_addr   = addr;
        bus.i_wdata  = wdata;
        @(posedge clk);
        #1 bus.i_req = 1'b0;
        r = '0;
        r.addrOk = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_ram_do == `RAM_READ)  r.nrd = r.nrd + 4'd1;
            if (bus.o_ram_do == `RAM_WRITE) r.nwr = r.nwr + 4'd1;
            if (bus.o_ram_do != `RAM_NOP && bus.o_ram_addr !== addr) r.addrOk = 1'b0;
            if (bus.o_done === 1'b1) begin
                seen    = 1'b1;
                r.lat   = 4'(k);
                r.fault = bus.o_fault;
                r.rdata = bus.o_rdata;
            end
        end
        if (!seen) $display("[TB] no o_done within 8 cycles for addr %08h", addr);
        obsQ.push_back(r);
    endtask

    task automatic test_reset();
        logic [100:0] got;
        logic [100:0] want;
        want = {1'b1, 1'b0, 1'b0, `RAM_NOP, 96'd0};
        rst          = 1'b1;
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b0;
        bus.i_size   = 2'd2;
        bus.i_signed = 1'b0;
        bus.i_addr   = 32'h10;
        bus.i_wdata  = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            got = {bus.o_ready, bus.o_done, bus.o_fault, bus.o_ram_do,
                   bus.o_rdata, bus.o_ram_addr, bus.o_ram_val};
            vecCount++;
            if (got !== want) begin
                missCount++;
                $display("[TB] FAIL reset_cycle%0d got=%026h want=%026h", c, got, want);
            end
        end
        bus.i_req = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_word();
        result_t exp;
        result_t got;
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, mk(1'b0, 32'h0, 2, 0, 1));
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        mk(1'b0, 32'hDEADBEEF, 2, 1, 0));
        for (int i = 0; sbQ.size() > 0; i++) begin
            exp = sbQ.pop_front();
            got = obsQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL word_%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_subword_load();
        result_t exp;
        result_t got;
        run_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, mk(1'b0, 32'hFFFFFFDE, 2, 1, 0));
        run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, mk(1'b0, 32'h0000BEEF, 2, 1, 0));
        run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, mk(1'b0, 32'hFFFFBEEF, 2, 1, 0));
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, mk(1'b0, 32'h000000EF, 2, 1, 0));
        run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, mk(1'b0, 32'hFFFFDEAD, 2, 1, 0));
        for (int i = 0; sbQ.size() > 0; i++) begin
            exp = sbQ.pop_front();
            got = obsQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL subload_%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_rmw();
        result_t exp;
        result_t got;
        run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, mk(1'b0, 32'h0, 3, 1, 1));
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        mk(1'b0, 32'hDE55BEEF, 2, 1, 0));
        run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, mk(1'b0, 32'h0, 2, 0, 1));
        run_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555CAFE, mk(1'b0, 32'h0, 3, 1, 1));
        run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        mk(1'b0, 32'h1122CAFE, 2, 1, 0));
        for (int i = 0; sbQ.size() > 0; i++) begin
            exp = sbQ.pop_front();
            got = obsQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL rmw_%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_fault();
        result_t exp;
        result_t got;
        run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,            mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF,     mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 3), 32'h0, mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES - 3), 32'h12345678, mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h99,     mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'hCAFEF00D, mk(1'b0, 32'h0, 2, 0, 1));
        run_req(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'h0, mk(1'b0, 32'hCAFEF00D, 2, 1, 0));
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,            mk(1'b0, 32'hDE55BEEF, 2, 1, 0));
        for (int i = 0; sbQ.size() > 0; i++) begin
            exp = sbQ.pop_front();
            got = obsQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL fault_%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_unaligned();
        result_t exp;
        result_t got;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, mk(1'b1, 32'h0, 1, 0, 0));
        run_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, mk(1'b1, 32'h0, 1, 0, 0));
`else
        run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, mk(1'b0, 32'h55BEEF00, 2, 1, 0));
        run_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, mk(1'b0, 32'h0000EF00, 2, 1, 0));
`endif
        run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, mk(1'b0, 32'h00000055, 2, 1, 0));
        for (int i = 0; sbQ.size() > 0; i++) begin
            exp = sbQ.pop_front();
            got = obsQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL unaligned_%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_rmw();
        result_t exp;
        result_t got;
        logic [4:0] snap;
        bit stray;
        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b1;
        bus.i_size   = 2'd0;
        bus.i_signed = 1'b0;
        bus.i_addr   = 32'h10;
        bus.i_wdata  = 32'h77;
        @(posedge clk);
        #1 bus.i_req = 1'b0;
        @(negedge clk);
        vecCount++;
        if (bus.o_ram_do !== `RAM_READ) begin
            missCount++;
            $display("[TB] FAIL rmw_abort_read got=%0d want=%0d", bus.o_ram_do, `RAM_READ);
        end
        rst = 1'b1;
        @(negedge clk);
        snap = {bus.o_ready, bus.o_done, bus.o_fault, bus.o_ram_do};
        vecCount++;
        if (snap !== {1'b1, 1'b0, 1'b0, `RAM_NOP}) begin
            missCount++;
            $display("[TB] FAIL rmw_abort_reset got=%05b want=%05b", snap, {1'b1, 1'b0, 1'b0, `RAM_NOP});
        end
        rst = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0 || bus.o_ram_do !== `RAM_NOP) stray = 1'b1;
        end
        vecCount++;
        if (stray !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rmw_abort_quiet got=%0b want=0", stray);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mk(1'b0, 32'hDE55BEEF, 2, 1, 0));
        exp = sbQ.pop_front();
        got = obsQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL rmw_abort_mem got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    // A request held high must be taken once per IDLE visit and never while busy.
    task automatic test_back_to_back();
        result_t exp;
        result_t got;
        logic [5:0] doneVec;
        logic [5:0] readyVec;
        int writes;
        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b1;
        bus.i_size   = 2'd2;
        bus.i_signed = 1'b0;
        bus.i_addr   = 32'h30;
        bus.i_wdata  = 32'h0BADF00D;
        doneVec  = '0;
        readyVec = '0;
        writes   = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            doneVec[k]  = bus.o_done;
            readyVec[k] = bus.o_ready;
            if (bus.o_ram_do == `RAM_WRITE) writes++;
        end
        bus.i_req = 1'b0;
        vecCount++;
        if (doneVec !== 6'b010010) begin
            missCount++;
            $display("[TB] FAIL b2b_done got=%06b want=010010", doneVec);
        end
        vecCount++;
        if (readyVec !== 6'b100100) begin
            missCount++;
            $display("[TB] FAIL b2b_ready got=%06b want=100100", readyVec);
        end
        vecCount++;
        if (writes !== 2) begin
            missCount++;
            $display("[TB] FAIL b2b_writes got=%0d want=2", writes);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, mk(1'b0, 32'h0BADF00D, 2, 1, 0));
        exp = sbQ.pop_front();
        got = obsQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL b2b_readback got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_rmw();
        test_fault();
        test_unaligned();
        test_reset_rmw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
